// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch stage with 2-entry prefetch buffer, redirect and halt
module instr_fetch_unit #(
    parameter int          ADDR_W    = 16,
    parameter int          DEPTH     = 256,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic              Clk,
    input  logic              Reset,
    output logic              Enable_i,
    output logic              RW_ram_i,
    output logic [ADDR_W-1:0] Address_in_i,
    input  logic [31:0]       Out_i,
    input  logic              Redirect,
    input  logic [ADDR_W-1:0] Redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instruction,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              Halted
);

    typedef enum logic {FETCH, HALT} state_t;

    localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [1:0]        count_q, count_d;
    logic [31:0]       word0_q, word0_d, word1_q, word1_d;
    logic [ADDR_W-1:0] pc0_q, pc0_d, pc1_q, pc1_d;

    logic              pop;
    logic              fetch;
    logic              push;
    logic [1:0]        count_after_pop;
    logic [ADDR_W-1:0] redirect_target;

    assign pop   = (count_q != 2'd0) && instr_ready;
    assign fetch = (state_q == FETCH) && !Redirect && ((count_q != 2'd2) || pop);
    assign push  = fetch && (Out_i != HALT_WORD);
    assign count_after_pop = count_q - {1'b0, pop};
    assign redirect_target = ADDR_W'({1'b0, Redirect_pc} % DEPTH_W);

    // Enable must not glitch high while the reset is holding the state cleared.
    assign Enable_i     = Reset && fetch;
    assign RW_ram_i     = 1'b1;
    assign Address_in_i = fetch_pc_q;
    assign instr_valid  = (count_q != 2'd0);
    assign instruction  = instr_valid ? word0_q : 32'd0;
    assign instr_pc     = instr_valid ? pc0_q : '0;
    assign Halted       = (state_q == HALT);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        word0_d    = word0_q;
        word1_d    = word1_q;
        pc0_d      = pc0_q;
        pc1_d      = pc1_q;

        if (pop) begin
            word0_d = word1_q;
            pc0_d   = pc1_q;
        end

        // A push lands behind whatever survives this cycle's pop.
        if (push) begin
            if (count_after_pop == 2'd0) begin
                word0_d = Out_i;
                pc0_d   = fetch_pc_q;
            end else begin
                word1_d = Out_i;
                pc1_d   = fetch_pc_q;
            end
            fetch_pc_d = (fetch_pc_q == LAST_PC) ? '0 : fetch_pc_q + 1'b1;
        end
        count_d = count_after_pop + {1'b0, push};

        if (fetch && !push) begin
            state_d = HALT;
        end

        if (Redirect) begin
            count_d    = 2'd0;
            fetch_pc_d = redirect_target;
            state_d    = FETCH;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= FETCH;
            fetch_pc_q <= '0;
            count_q    <= 2'd0;
            word0_q    <= 32'd0;
            word1_q    <= 32'd0;
            pc0_q      <= '0;
            pc1_q      <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            word0_q    <= word0_d;
            word1_q    <= word1_d;
            pc0_q      <= pc0_d;
            pc1_q      <= pc1_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;

    localparam int          ADDR_W = 16;
    localparam int          DEPTH  = 16;
    localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              Enable_i;
    logic              RW_ram_i;
    logic [ADDR_W-1:0] Address_in_i;
    logic [31:0]       Out_i;
    logic              Redirect;
    logic [ADDR_W-1:0] Redirect_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instruction;
    logic [ADDR_W-1:0] instr_pc;
    logic              Halted;

    logic [31:0] mem [16];
    logic [47:0] exp_q[$];
    logic [47:0] obs_q[$];
    int          obs_cyc[$];
    int          cyc;
    int          tests_run;
    int          tests_failed;

    always #5 Clk = ~Clk;

    assign Out_i = (Address_in_i < 16) ? mem[Address_in_i[3:0]] : 32'hDEAD_BEEF;

    instr_fetch_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .HALT_WORD(HALT_W)) dut (
        .Clk(Clk), .Reset(Reset), .Enable_i(Enable_i), .RW_ram_i(RW_ram_i),
        .Address_in_i(Address_in_i), .Out_i(Out_i), .Redirect(Redirect),
        .Redirect_pc(Redirect_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instruction(instruction), .instr_pc(instr_pc), .Halted(Halted)
    );

    task automatic do_reset();
        Reset       = 1'b0;
        Redirect    = 1'b0;
        Redirect_pc = '0;
        instr_ready = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        exp_q.delete();
        obs_q.delete();
        obs_cyc.delete();
        cyc = 0;
    endtask

    // Records the handshake that the coming rising edge will perform, then advances one cycle.
    task automatic cycle();
        #1;
        if (instr_valid && instr_ready) begin
            obs_q.push_back({instruction, instr_pc});
            obs_cyc.push_back(cyc);
        end
        @(negedge Clk);
        cyc++;
    endtask

    task automatic test_reset();
        Reset = 1'b0; Redirect = 1'b0; Redirect_pc = '0; instr_ready = 1'b1;
        #1;
        tests_run++;
        if ({Enable_i, Address_in_i, instr_valid, instruction, instr_pc, Halted} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs got en=%b addr=%0d v=%b ins=%h pc=%0d h=%b want all 0",
                     Enable_i, Address_in_i, instr_valid, instruction, instr_pc, Halted);
        end
        tests_run++;
        if (RW_ram_i !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_rw got %b want 1", RW_ram_i);
        end
    endtask

    task automatic test_stream();
        logic [47:0] e, o;
        int          c0;
        do_reset();
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back({mem[i], 16'(i)});
        #1;
        tests_run++;
        if (Enable_i !== 1'b1 || Address_in_i !== 16'd0) begin
            tests_failed++;
            $display("FAIL first_fetch got en=%b addr=%0d want en=1 addr=0", Enable_i, Address_in_i);
        end
        for (int i = 0; i < 5; i++) cycle();
        tests_run++;
        if (obs_q.size() != 4 || obs_cyc[0] != 1) begin
            tests_failed++;
            $display("FAIL stream_count got n=%0d want n=4 first at cycle 1", obs_q.size());
        end
        c0 = 1;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests_run++;
            if (o !== e || obs_cyc.pop_front() != c0) begin
                tests_failed++;
                $display("FAIL stream_entry got %h want %h at cycle %0d", o, e, c0);
            end
            c0++;
        end
    endtask

    task automatic test_backpressure();
        logic [47:0] e, o;
        do_reset();
        for (int i = 0; i < 5; i++) cycle();
        #1;
        tests_run++;
        if (Enable_i !== 1'b0 || Address_in_i !== 16'd2 || instr_pc !== 16'd0 || instruction !== mem[0]) begin
            tests_failed++;
            $display("FAIL bp_full got en=%b addr=%0d pc=%0d want en=0 addr=2 pc=0",
                     Enable_i, Address_in_i, instr_pc);
        end
        instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back({mem[i], 16'(i)});
        for (int i = 0; i < 3; i++) cycle();
        tests_run++;
        if (obs_q.size() != 3) begin
            tests_failed++;
            $display("FAIL bp_count got %0d want 3", obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL bp_entry got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_redirect();
        logic [47:0] e, o;
        do_reset();
        for (int i = 0; i < 3; i++) cycle();
        Redirect = 1'b1; Redirect_pc = 16'h000A;
        cycle();
        Redirect = 1'b0;
        #1;
        tests_run++;
        if (instr_valid !== 1'b0 || Address_in_i !== 16'd10 || Enable_i !== 1'b1) begin
            tests_failed++;
            $display("FAIL redir_flush got v=%b addr=%0d en=%b want v=0 addr=10 en=1",
                     instr_valid, Address_in_i, Enable_i);
        end
        instr_ready = 1'b1;
        exp_q.push_back({mem[10], 16'd10});
        exp_q.push_back({mem[11], 16'd11});
        for (int i = 0; i < 3; i++) cycle();
        tests_run++;
        if (obs_q.size() != 2) begin
            tests_failed++;
            $display("FAIL redir_count got %0d want 2", obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL redir_entry got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_halt();
        logic [47:0] e, o;
        logic [31:0] saved;
        saved  = mem[3];
        mem[3] = HALT_W;
        do_reset();
        instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back({mem[i], 16'(i)});
        for (int i = 0; i < 4; i++) cycle();
        #1;
        tests_run++;
        if (Halted !== 1'b1 || Enable_i !== 1'b0 || Address_in_i !== 16'd3) begin
            tests_failed++;
            $display("FAIL halt_enter got h=%b en=%b addr=%0d want h=1 en=0 addr=3",
                     Halted, Enable_i, Address_in_i);
        end
        for (int i = 0; i < 3; i++) cycle();
        tests_run++;
        if (obs_q.size() != 3 || Enable_i !== 1'b0 || instr_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL halt_hold got n=%0d en=%b v=%b want n=3 en=0 v=0",
                     obs_q.size(), Enable_i, instr_valid);
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL halt_entry got %h want %h", o, e);
            end
        end
        mem[3]   = saved;
        Redirect = 1'b1; Redirect_pc = 16'd0;
        cycle();
        Redirect = 1'b0;
        #1;
        tests_run++;
        if (Halted !== 1'b0) begin
            tests_failed++;
            $display("FAIL halt_exit got %b want 0", Halted);
        end
        exp_q.push_back({mem[0], 16'd0});
        for (int i = 0; i < 2; i++) cycle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 48'hX;
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL halt_refetch got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_wrap();
        logic [47:0] e, o;
        do_reset();
        instr_ready = 1'b1;
        Redirect = 1'b1; Redirect_pc = 16'd14;
        cycle();
        Redirect = 1'b0;
        exp_q.push_back({mem[14], 16'd14});
        exp_q.push_back({mem[15], 16'd15});
        exp_q.push_back({mem[0], 16'd0});
        exp_q.push_back({mem[1], 16'd1});
        for (int i = 0; i < 5; i++) cycle();
        // Redirect arrives with pc 2 at the head; that pop still completes.
        exp_q.push_back({mem[2], 16'd2});
        Redirect = 1'b1; Redirect_pc = 16'd17;
        cycle();
        Redirect = 1'b0;
        exp_q.push_back({mem[1], 16'd1});
        for (int i = 0; i < 2; i++) cycle();
        tests_run++;
        if (obs_q.size() != 6) begin
            tests_failed++;
            $display("FAIL wrap_count got %0d want 6", obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL wrap_entry got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 3; i++) cycle();
        #2;
        Reset = 1'b0;
        #1;
        tests_run++;
        if (instr_valid !== 1'b0 || Address_in_i !== 16'd0 || Enable_i !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset got v=%b addr=%0d en=%b want 0 0 0",
                     instr_valid, Address_in_i, Enable_i);
        end
        @(negedge Clk);
        Reset = 1'b1; instr_ready = 1'b1;
        obs_q.delete();
        #1;
        tests_run++;
        if (Enable_i !== 1'b1 || Address_in_i !== 16'd0) begin
            tests_failed++;
            $display("FAIL async_refetch got en=%b addr=%0d want en=1 addr=0", Enable_i, Address_in_i);
        end
        @(negedge Clk);
        cycle();
        tests_run++;
        if (obs_q.size() != 1 || obs_q[0] !== {mem[0], 16'd0}) begin
            tests_failed++;
            $display("FAIL async_first got n=%0d want one entry %h", obs_q.size(), {mem[0], 16'd0});
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        cyc          = 0;
        for (int i = 0; i < 16; i++) mem[i] = 32'hA0 + 32'(i);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_halt();
        test_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage for the Master CPU. Replaces hand-stepped instruction addressing with a self-running program counter. Each cycle it drives the read-only port of the instruction RAM, captures the returned word into a 2-entry prefetch buffer, and presents instructions to the decode/execute stage over a valid/ready handshake. It supports a redirect input for branches and stops fetching on a halt word.

## Interface
- ADDR_W, 16, width of the instruction RAM address and of all PC values
- DEPTH, 256, number of instruction words; PC wraps modulo DEPTH
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch
- Clk  input  1  single clock; all state changes on rising edge
- Reset  input  1  asynchronous, active-low; clears all state immediately when low
- Enable_i  output  1  instruction RAM enable; high only in a cycle that fetches
- RW_ram_i  output  1  instruction RAM read/write select; constant 1 (read)
- Address_in_i  output  ADDR_W  instruction RAM address; equals fetch_pc register
- Out_i  input  32  instruction RAM read data; valid combinationally in the same cycle as Address_in_i
- Redirect  input  1  one-cycle pulse: flush buffer and restart fetch at Redirect_pc
- Redirect_pc  input  ADDR_W  redirect target, reduced modulo DEPTH
- instr_valid  output  1  buffer head holds a valid instruction
- instr_ready  input  1  downstream accepts head this cycle
- instruction  output  32  head instruction word (Cond[31:28], OpCode[27:24], ...); 0 when empty
- instr_pc  output  ADDR_W  address the head word was fetched from; 0 when empty
- Halted  output  1  fetch stopped by HALT_WORD

## Operation
- State: fetch_pc, 2-entry FIFO of {word, pc}, count (0..2), FSM {FETCH, HALT}.
- Reset (low): fetch_pc=0, count=0, state=FETCH; outputs Enable_i=0, Address_in_i=0, instr_valid=0, instruction=0, instr_pc=0, Halted=0. Enable_i is gated low while Reset is low.
- Pop: instr_valid & instr_ready at an edge removes the head.
- Fetch condition: state==FETCH, Redirect==0, and (count<2 or pop this cycle). Enable_i equals the fetch condition.
- A fetch at an edge with Out_i != HALT_WORD pushes {Out_i, fetch_pc} and sets fetch_pc <= (fetch_pc+1) mod DEPTH.
- A fetch at an edge with Out_i == HALT_WORD does not push. It sets state=HALT and leaves fetch_pc pointing at the halt word.
- HALT: Enable_i=0; buffer keeps draining normally; Halted=1. Only Redirect or Reset leaves HALT.
- Redirect (highest priority): a head pop in the same cycle completes. Then count=0, fetch_pc=Redirect_pc mod DEPTH, state=FETCH, Halted=0. No push that cycle.
- Simultaneous push and pop at count==2 is allowed; count stays 2. Order is strictly FIFO, with no loss or duplication.

## Timing
- Fetch-to-output latency is 1 cycle. A word addressed in cycle n is at the head (if the buffer was empty) after edge n.
- First fetch: the first rising edge after Reset deasserts fetches address 0. instr_valid rises after that edge.
- Sustained throughput is 1 instruction/cycle while instr_ready=1.
- Backpressure: with instr_ready=0, two fetches fill the buffer. Enable_i then drops and Address_in_i holds the next unfetched PC.
- Redirect in cycle n: the head is invalid after edge n. The target is fetched in cycle n+1 and valid after edge n+1.
- Halted rises after the edge that sampled HALT_WORD.
- Reset asserted mid-operation clears all state asynchronously, without waiting for Clk. A pending buffer is discarded.

## Test plan
- Load words 0..3 = 32'hA0..A3, hold instr_ready=1 from reset release. Expect instruction A0, A1, A2, A3 on consecutive cycles, with instr_pc 0, 1, 2, 3.
- Hold instr_ready=0 for 5 cycles after reset. Expect Enable_i low after 2 fetches and Address_in_i=2. Raise ready: expect A0, A1, A2 in order, no duplicates.
- Pulse Redirect with Redirect_pc=16'h000A while 2 entries are buffered. Expect instr_valid=0 next cycle, then instr_pc=10 with word[10], and no stale entries.
- Place HALT_WORD at address 3, ready=1. Expect words 0..2 delivered and Halted=1 after the edge fetching 3. Expect Enable_i=0 thereafter, pc 3 never delivered. Then Redirect to 0: expect Halted=0 and word[0] re-fetched.
- Set DEPTH=16, Redirect to 14. Expect instr_pc sequence 14, 15, 0, 1. Redirect to 17: expect instr_pc=1.
- Drop Reset between edges while count==2. Expect instr_valid=0, Address_in_i=0, Enable_i=0 immediately. After release, expect the fetch of 0 on the first edge.
